// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops CPU stores into a byte FIFO, serialises them on tx.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        rd_hit,
    output logic        tx,
    output logic        busy
);

    localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW       = 7;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_FLAG = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic PAR_FLAG = 1'b0;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    state_t        state_q;
    logic [15:0]   baud_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          par_q;

    logic full, empty, push_req, stat_wr, pop, push_ok, baud_done;
    logic unused_wdata;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign push_req  = MemWrite && (DataAdr == BASE_ADDR);
    assign stat_wr   = MemWrite && (DataAdr == BASE_ADDR + 32'd4);
    // Pop decision uses the registered count, so a push never bypasses an empty FIFO.
    assign pop       = (state_q == IDLE) && !empty;
    assign push_ok   = push_req && (!full || pop);
    assign baud_done = (baud_q == '0);
    assign unused_wdata = ^WriteData[31:8];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (stat_wr && WriteData[2]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        par_q   <= ^mem_q[rd_ptr_q];
                        baud_q  <= BAUD_MAX;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= BAUD_MAX;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= BAUD_MAX;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_q  <= BAUD_MAX;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !empty;
    assign rd_hit   = (DataAdr == BASE_ADDR + 32'd4);
    assign ReadData = rd_hit ? {PAR_FLAG, 20'b0, count_q, (state_q != IDLE), ovf_q, empty, full}
                             : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx with a frame-timer reference model and per-cycle comparison.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        rd_hit, tx, busy;

  int n_checks = 0;
  int n_errors = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .rd_hit(rd_hit), .tx(tx), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bytes waiting, plus a timer for the frame on the wire
  logic [7:0] exp_q[$];
  logic [7:0] cur;
  bit         active;
  int         pos;
  bit         m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      active = 0;
      pos    = 0;
      m_ovf  = 0;
    end else begin
      if (active) begin
        pos++;
        if (pos == FRAME) active = 0;
      end else if (exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        active = 1;
        pos    = 0;
      end
      if (MemWrite && DataAdr == BASE) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(WriteData[7:0]);
        else m_ovf = 1;
      end else if (MemWrite && DataAdr == BASE + 32'd4 && WriteData[2]) begin
        m_ovf = 0;
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!active) return 1'b1;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    if (NBITS == 11 && k == 9) return ^cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int sz;
    sz = exp_q.size();
    return {PAR, 20'b0, 7'(sz), 1'(active), 1'(m_ovf), 1'(sz == 0), 1'(sz == DEPTH)};
  endfunction

  always @(negedge clk) begin
    logic hit;
    hit = (DataAdr == BASE + 32'd4);
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy}, {31'b0, 1'(active || exp_q.size() > 0)});
    check("rd_hit", {31'b0, rd_hit}, {31'b0, hit});
    check("rdata", ReadData, hit ? exp_status() : 32'b0);
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      MemWrite = 1'b0;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    MemWrite = 1'b1; DataAdr = addr; WriteData = data;
    @(posedge clk); #1;
    MemWrite = 1'b0; DataAdr = BASE + 32'd4;
  endtask

  initial begin
    logic [31:0] addrs [6];
    addrs[0] = BASE; addrs[1] = BASE + 32'd4; addrs[2] = 32'h0FF;
    addrs[3] = 32'h101; addrs[4] = 32'h108; addrs[5] = 32'h0;

    DataAdr = BASE + 32'd4;
    idle(3);
    @(posedge clk); #1 reset = 1'b0;
    idle(2);
    check("status_after_reset", ReadData, 32'h0000_0002);

    // single byte
    store(BASE, 32'h0000_00A5);
    idle(FRAME + 5);

    // reset mid-frame
    store(BASE, 32'h0000_0055);
    idle(30);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    DataAdr = BASE + 32'd4;
    #1 check("reset_status", ReadData, 32'h0000_0002);
    idle(3);

    // fill and overflow
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      MemWrite = 1'b1; DataAdr = BASE; WriteData = {$urandom_range(0, 255), 8'(i)};
    end
    @(posedge clk); #1;
    MemWrite = 1'b0; DataAdr = BASE + 32'd4;
    #1;
    check("ovf_flag", {31'b0, ReadData[2]}, 32'd1);
    check("full_flag", {31'b0, ReadData[0]}, 32'd1);
    store(BASE + 32'd4, 32'h0000_0004);
    #1 check("ovf_cleared", {31'b0, ReadData[2]}, 32'd0);
    idle(10 * (FRAME + 1) + 5);

    // decode: neighbouring addresses do nothing
    store(32'h0FF, 32'h0000_0011);
    store(32'h101, 32'h0000_0022);
    store(32'h108, 32'h0000_0033);
    @(posedge clk); #1 DataAdr = BASE;
    #1 check("rd_hit_base", {31'b0, rd_hit}, 32'd0);
    check("rdata_base", ReadData, 32'd0);
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      MemWrite  = ($urandom_range(0, 99) < 20);
      DataAdr   = addrs[$urandom_range(0, 5)];
      WriteData = $urandom;
      if (DataAdr == 32'h0) DataAdr = $urandom;
    end
    @(posedge clk); #1 MemWrite = 1'b0;
    idle((DEPTH + 1) * (FRAME + 1) + 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
